// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter serialising word, half and byte accesses onto a byte-wide memory.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict arbitration; otherwise the data port always wins.
module mem_port_arbiter #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [2:0]    d_func3,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [1:0]    last_beat;
  logic          gnt_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [23:0]   coll;
  logic [31:0]   coll_next;
  logic [1:0]    byte_sel;
  logic          take_d;

  // Access size expressed as index of the final beat; bit 2 (signedness) plays no part.
  function automatic logic [1:0] size_last(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_last = 2'd0;
      2'b01:   size_last = 2'd1;
      default: size_last = 2'd3;
    endcase
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  assign take_d = d_req && (!i_req || !last_d);
`else
  assign take_d = d_req;
`endif

  // Big-endian byte order: beat 0 carries the most significant byte of the access.
  assign byte_sel  = last_beat - cnt;
  assign mem_addr  = addr_q + AW'(cnt);
  assign mem_we    = (state == BEAT) && we_q;
  assign mem_wdata = wdata_q[{byte_sel, 3'b000} +: 8];
  assign coll_next = {coll, mem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      last_beat <= 2'd0;
      gnt_d     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      coll      <= 24'd0;
      busy      <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b0;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state <= BEAT;
            busy  <= 1'b1;
            cnt   <= 2'd0;
            coll  <= 24'd0;
            gnt_d <= take_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d <= take_d;
`endif
            if (take_d) begin
              addr_q    <= d_addr;
              we_q      <= d_we;
              wdata_q   <= d_wdata;
              last_beat <= size_last(d_func3);
            end else begin
              addr_q    <= i_addr;
              we_q      <= 1'b0;
              last_beat <= 2'd3;
            end
          end
        end
        BEAT: begin
          cnt  <= cnt + 2'd1;
          coll <= coll_next[23:0];
          if (cnt == last_beat) begin
            state <= DONE;
            if (gnt_d) begin
              d_ack   <= 1'b1;
              d_rdata <= coll_next;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= coll_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
